regs_file_mp: RTL
=================

REGS_FILE_MP -- requirements
Module: regs_file_mp

Interface
REQ-001 Parameter N, default 32, register data width in bits.
REQ-002 Parameter A, default 5, address width; register count is 2**A.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 we0  input  1  write enable, write port 0.
REQ-006 wa0  input  A  write address, port 0.
REQ-007 wd0  input  N  write data, port 0.
REQ-008 we1  input  1  write enable, write port 1 (priority port).
REQ-009 wa1  input  A  write address, port 1.
REQ-010 wd1  input  N  write data, port 1.
REQ-011 ra0  input  A  read address, port 0.
REQ-012 ra1  input  A  read address, port 1.
REQ-013 rd0  output N  read data, port 0, combinational.
REQ-014 rd1  output N  read data, port 1, combinational.
REQ-015 rsv_en  input  1  reserve (mark pending write) request.
REQ-016 rsv_addr  input  A  register to reserve.
REQ-017 busy0  output 1  scoreboard bit of ra0, combinational.
REQ-018 busy1  output 1  scoreboard bit of ra1, combinational.
REQ-019 ready  output 1  high when clear sequence done and block accepts traffic.

Function
REQ-020 Address 0 SHALL read as zero always; writes and reservations to address 0 SHALL be ignored; busy for address 0 SHALL be 0.
REQ-021 States: CLEAR, RUN; rst SHALL force CLEAR with clear counter = 1 regardless of current state.
REQ-022 In CLEAR, each cycle with rst low SHALL write zero to register[counter] and increment counter; after writing address 2**A-1 the next state SHALL be RUN.
REQ-023 After rst deasserts, ready SHALL rise exactly 2**A-1 cycles later (32-entry default: 31 cycles); ready SHALL be 0 while rst high and in CLEAR.
REQ-024 rst re-asserted mid-CLEAR SHALL restart the sequence at counter 1.
REQ-025 While ready is 0: rd0, rd1, busy0, busy1 SHALL be 0; writes and reservations SHALL be ignored.
REQ-026 In RUN, a write with we_k=1 SHALL update register[wa_k] with wd_k at the next rising edge.
REQ-027 Both write ports to the same nonzero address in one cycle: port 1 data SHALL be stored.
REQ-028 Read bypass: if ready and we_k=1 and wa_k==ra_j!=0, rd_j SHALL return wd_k in the same cycle (port 1 over port 0), else the stored value.
REQ-029 Scoreboard: one busy bit per register; rsv_en in RUN SHALL set busy[rsv_addr] at the next edge.
REQ-030 A write on either port SHALL clear busy[wa_k] at the next edge.
REQ-031 Reserve and write to the same address in one cycle: busy SHALL end set (reservation wins); data write still occurs.
REQ-032 busy0/busy1 SHALL reflect registered scoreboard state only (no same-cycle bypass).
REQ-033 All data paths SHALL be exactly N bits; no truncation or sign extension.

Reset
REQ-034 rst high SHALL clear all busy bits at the next edge and set ready to 0.
REQ-035 Register contents SHALL be zero for every address once ready rises.
REQ-036 rst held high for any number of cycles SHALL keep state CLEAR, counter 1, no register writes.

Verification
REQ-037 Pulse rst 1 cycle, count cycles -> ready rises after 31 cycles (N=32,A=5); all 32 addresses read 0.
REQ-038 Write 0xDEADBEEF to reg 5 via port 0, same cycle read ra0=5 -> rd0=0xDEADBEEF same cycle and next cycle.
REQ-039 we0 wa0=7 wd0=0x11, we1 wa1=7 wd1=0x22 same cycle -> rd of 7 = 0x22 next cycle; write to reg 0 -> reads 0.
REQ-040 rsv_en addr 9 -> busy0=1 (ra0=9) next cycle; write reg 9 -> busy0=0 next cycle; rsv+write reg 9 together -> busy stays 1.
REQ-041 Assert rst at counter 15 in CLEAR -> ready low, sequence restarts, ready rises 31 cycles after rst drops.
REQ-042 Reset from RUN with reg 3=0xA5A5A5A5 and busy[3]=1 -> busy0=0 immediately after edge, reg 3 reads 0 after ready.

Source files
------------

// File: rtl/regs_file_mp.sv
// regs_file_mp: multi-port register file with pending-write scoreboard.
//
// Two write ports (port 1 has priority on address collisions), two
// combinational read ports with same-cycle write bypass, and one busy bit
// per register that marks a reserved (pending) write. Address 0 is
// hard-wired to zero. After reset the block walks addresses 1..2**A-1
// writing zero, then raises ready and accepts traffic.
//
// State table:
//   CLEAR | zeroing registers, counter = next address to clear, ready low
//   RUN   | normal operation, ready high
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   we0/wa0/wd0         write port 0
//   we1/wa1/wd1         write port 1 (wins on same-address writes)
//   ra0/ra1 -> rd0/rd1  combinational read ports with write bypass
//   rsv_en/rsv_addr     reserve request, sets busy[rsv_addr]
//   busy0/busy1         registered busy bit of ra0/ra1
//   ready               clear sequence done
module regs_file_mp #(
  parameter int N = 32,
  parameter int A = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we0,
  input  logic [A-1:0] wa0,
  input  logic [N-1:0] wd0,
  input  logic         we1,
  input  logic [A-1:0] wa1,
  input  logic [N-1:0] wd1,
  input  logic [A-1:0] ra0,
  input  logic [A-1:0] ra1,
  output logic [N-1:0] rd0,
  output logic [N-1:0] rd1,
  input  logic         rsv_en,
  input  logic [A-1:0] rsv_addr,
  output logic         busy0,
  output logic         busy1,
  output logic         ready
);

  localparam int            DEPTH = 2 ** A;
  localparam logic [A-1:0]  ADDR_ONE  = A'(1);
  localparam logic [A-1:0]  ADDR_LAST = {A{1'b1}};

  typedef enum logic {CLEAR, RUN} state_t;

  state_t             state;
  logic [A-1:0]       cnt;
  logic [DEPTH-1:0]   busy;
  logic [N-1:0]       mem [DEPTH];

  logic wr0_ok, wr1_ok, rsv_ok;

  assign wr0_ok = ready && we0 && (wa0 != '0);
  assign wr1_ok = ready && we1 && (wa1 != '0);
  assign rsv_ok = ready && rsv_en && (rsv_addr != '0);

  // Control: sequencing state, clear counter, ready and scoreboard.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= ADDR_ONE;
      ready <= 1'b0;
      busy  <= '0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + ADDR_ONE;
          if (cnt == ADDR_LAST) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          // Write clears come first so a same-cycle reservation wins.
          if (wr0_ok) busy[wa0] <= 1'b0;
          if (wr1_ok) busy[wa1] <= 1'b0;
          if (rsv_ok) busy[rsv_addr] <= 1'b1;
        end
        default: begin
          state <= CLEAR;
          cnt   <= ADDR_ONE;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage: no reset on the array itself; the clear walk zeroes it.
  // Entry 0 is never written and never read out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[cnt] <= '0;
      end else begin
        if (wr0_ok) mem[wa0] <= wd0;
        if (wr1_ok) mem[wa1] <= wd1;  // later assignment gives port 1 priority
      end
    end
  end

  always_comb begin
    rd0 = '0;
    if (ready && (ra0 != '0)) begin
      if (wr1_ok && (wa1 == ra0))      rd0 = wd1;
      else if (wr0_ok && (wa0 == ra0)) rd0 = wd0;
      else                             rd0 = mem[ra0];
    end
  end

  always_comb begin
    rd1 = '0;
    if (ready && (ra1 != '0)) begin
      if (wr1_ok && (wa1 == ra1))      rd1 = wd1;
      else if (wr0_ok && (wa0 == ra1)) rd1 = wd0;
      else                             rd1 = mem[ra1];
    end
  end

  assign busy0 = ready && busy[ra0];
  assign busy1 = ready && busy[ra1];

endmodule
